rs_seq: RTL and testbench

Sequential 8-bit logarithmic right shifter, the right-direction counterpart to the barrel shifter's left-shift stages. It accepts an operand, a 3-bit shift amount and a mode on a start strobe. It applies the shift-by-4, shift-by-2 and shift-by-1 stages on successive cycles and returns the result with a one-cycle done pulse. It sits beside the combinational left barrel shifter and serves datapaths that can tolerate multi-cycle latency in exchange for one stage of shift hardware.

---
 rtl/rs_seq_pkg.sv | 29 ++
 rtl/rs_seq_stage.sv | 32 +++
 rtl/rs_seq.sv | 113 +++++++++++
 tb/tb_rs_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rs_seq_pkg.sv
// Shared encodings and helpers for the sequential logarithmic right shifter.
package rs_seq_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ST4  = 2'd1,
        S_ST2  = 2'd2,
        S_ST1  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIST_4 = 2'd0,
        DIST_2 = 2'd1,
        DIST_1 = 2'd2
    } dist_e;

    // Arithmetic mode propagates the operand sign; every other mode shifts in zero.
    function automatic logic fill_bit(input logic [1:0] mode, input logic signed [DATA_W-1:0] operand);
        return (mode == MODE_ASR) ? operand[DATA_W-1] : 1'b0;
    endfunction

endpackage

// File: rtl/rs_seq_stage.sv
// One shared right-shift stage: shift by 4, 2 or 1 with fill or rotate, bypassable.
module rs_stage
    import rs_seq_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  dist_e             dist_i,
    input  logic              en_i,
    input  logic              rot_i,
    input  logic              fill_i,
    output logic [DATA_W-1:0] data_o
);

    logic [3:0]          upper;
    logic [DATA_W+2:0]   ext;
    logic [DATA_W-1:0]   shifted;

    // Bits entering from the top: wrapped-around LSBs for rotate, else the fill bit.
    assign upper = rot_i ? data_i[3:0] : {4{fill_i}};
    assign ext   = {upper, data_i[DATA_W-1:1]};

    always_comb begin
        shifted = data_i;
        unique case (dist_i)
            DIST_4:  shifted = ext[DATA_W+2:3];
            DIST_2:  shifted = ext[DATA_W:1];
            DIST_1:  shifted = ext[DATA_W-1:0];
            default: shifted = data_i;
        endcase
        data_o = en_i ? shifted : data_i;
    end

endmodule

// File: rtl/rs_seq.sv
// Sequential 8-bit right shifter: one shared stage applied for 4, 2, 1 on successive cycles.
module rs_seq
    import rs_seq_pkg::*;
#(
    parameter bit BYPASS_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [AMT_W-1:0]  amt,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [1:0]        mode_q, mode_d;
    logic              fill_q, fill_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              done_q, done_d;

    dist_e             stage_dist;
    logic              stage_en;
    logic [DATA_W-1:0] stage_out;

    rs_stage u_stage (
        .data_i (data_q),
        .dist_i (stage_dist),
        .en_i   (stage_en),
        .rot_i  (mode_q == MODE_ROR),
        .fill_i (fill_q),
        .data_o (stage_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
            fill_q  <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        amt_d      = amt_q;
        mode_d     = mode_q;
        fill_d     = fill_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        stage_dist = DIST_4;
        stage_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (BYPASS_ZERO && (amt == '0)) begin
                        dout_d = din;
                        done_d = 1'b1;
                    end else begin
                        data_d  = din;
                        amt_d   = amt;
                        mode_d  = mode;
                        fill_d  = fill_bit(mode, din);
                        state_d = S_ST4;
                    end
                end
            end
            S_ST4: begin
                stage_dist = DIST_4;
                stage_en   = amt_q[2];
                data_d     = stage_out;
                state_d    = S_ST2;
            end
            S_ST2: begin
                stage_dist = DIST_2;
                stage_en   = amt_q[1];
                data_d     = stage_out;
                state_d    = S_ST1;
            end
            S_ST1: begin
                // Final stage writes straight into dout so done and result align.
                stage_dist = DIST_1;
                stage_en   = amt_q[0];
                dout_d     = stage_out;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_rs_seq.sv
// Testbench for rs_seq: two instances (bypass off/on) checked against a shift model.
module tb_rs_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic [2:0] amt;
    logic [1:0] mode;
    logic       busy0, done0, busy1, done1;
    logic [7:0] dout0, dout1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rs_seq #(.BYPASS_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .din(din), .amt(amt), .mode(mode),
        .busy(busy0), .done(done0), .dout(dout0)
    );

    rs_seq #(.BYPASS_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .din(din), .amt(amt), .mode(mode),
        .busy(busy1), .done(done1), .dout(dout1)
    );

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
        logic [15:0] dd;
        logic signed [7:0] sd;
        case (m)
            2'b01: begin
                sd = $signed(d) >>> a;
                return sd;
            end
            2'b10: begin
                dd = {d, d} >> a;
                return dd[7:0];
            end
            default: return d >> a;
        endcase
    endfunction

    // One request observed on both instances over a six-cycle window.
    task automatic run_both(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m, input string tag);
        int lat0, lat1, b0, b1, n0, n1, elat1, eb1;
        logic [7:0] r0, r1, exp;
        exp = model(d, a, m);
        elat1 = (a == 3'd0) ? 1 : 4;
        eb1   = (a == 3'd0) ? 0 : 3;
        lat0 = -1; lat1 = -1; b0 = 0; b1 = 0; n0 = 0; n1 = 0; r0 = 8'h00; r1 = 8'h00;
        start = 1'b1; din = d; amt = a; mode = m;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                din = 8'($urandom); amt = 3'($urandom); mode = 2'($urandom);
            end
            if (busy0) b0++;
            if (busy1) b1++;
            if (done0) begin
                n0++;
                if (lat0 < 0) begin lat0 = i; r0 = dout0; end
            end
            if (done1) begin
                n1++;
                if (lat1 < 0) begin lat1 = i; r1 = dout1; end
            end
        end
        checks++; if (r0 !== exp) begin failures++; $display("FAIL %s dout0 got=%h exp=%h", tag, r0, exp); end
        checks++; if (lat0 != 4) begin failures++; $display("FAIL %s lat0 got=%0d exp=4", tag, lat0); end
        checks++; if (b0 != 3) begin failures++; $display("FAIL %s busy0_cycles got=%0d exp=3", tag, b0); end
        checks++; if (n0 != 1) begin failures++; $display("FAIL %s done0_count got=%0d exp=1", tag, n0); end
        checks++; if (dout0 !== exp) begin failures++; $display("FAIL %s dout0_hold got=%h exp=%h", tag, dout0, exp); end
        checks++; if (r1 !== exp) begin failures++; $display("FAIL %s dout1 got=%h exp=%h", tag, r1, exp); end
        checks++; if (lat1 != elat1) begin failures++; $display("FAIL %s lat1 got=%0d exp=%0d", tag, lat1, elat1); end
        checks++; if (b1 != eb1) begin failures++; $display("FAIL %s busy1_cycles got=%0d exp=%0d", tag, b1, eb1); end
        checks++; if (n1 != 1) begin failures++; $display("FAIL %s done1_count got=%0d exp=1", tag, n1); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; din = 8'hFF; amt = 3'd7; mode = 2'b01;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset busy0 got=%b exp=0", busy0); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset done0 got=%b exp=0", done0); end
        checks++; if (dout0 !== 8'h00) begin failures++; $display("FAIL reset dout0 got=%h exp=00", dout0); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset busy1 got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset done1 got=%b exp=0", done1); end
        checks++; if (dout1 !== 8'h00) begin failures++; $display("FAIL reset dout1 got=%h exp=00", dout1); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_both(8'hB4, 3'd2, 2'b00, "lsr_b4_2");
        run_both(8'hB4, 3'd3, 2'b01, "asr_b4_3");
        run_both(8'h74, 3'd3, 2'b01, "asr_74_3");
        run_both(8'h81, 3'd1, 2'b10, "ror_81_1");
        run_both(8'h80, 3'd7, 2'b00, "lsr_80_7");
        run_both(8'h5A, 3'd0, 2'b11, "rsv_5a_0");
        run_both(8'h3C, 3'd0, 2'b00, "bypass_3c");
        run_both(8'hE1, 3'd7, 2'b10, "ror_e1_7");
    endtask

    task automatic test_busy_ignore();
        int n;
        logic [7:0] r;
        n = 0; r = 8'h00;
        start = 1'b1; din = 8'hB4; amt = 3'd2; mode = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 2) begin start = 1'b1; din = 8'hFF; amt = 3'd1; mode = 2'b01; end
            if (i == 3) start = 1'b0;
            if (done0) begin n++; if (n == 1) r = dout0; end
        end
        checks++; if (r !== 8'h2D) begin failures++; $display("FAIL busy_ignore dout got=%h exp=2d", r); end
        checks++; if (n != 1) begin failures++; $display("FAIL busy_ignore done_count got=%0d exp=1", n); end
    endtask

    task automatic test_back_to_back();
        bit found;
        int lat;
        logic [7:0] r;
        found = 1'b0; lat = -1; r = 8'h00;
        start = 1'b1; din = 8'h81; amt = 3'd1; mode = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done0) begin found = 1'b1; break; end
        end
        checks++; if (!found || dout0 !== 8'hC0) begin failures++; $display("FAIL b2b first found=%0d dout got=%h exp=c0", found, dout0); end
        start = 1'b1; din = 8'hB4; amt = 3'd3; mode = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL b2b done_width got=%b exp=0", done0); end
            end
            if (done0) begin lat = i; r = dout0; break; end
        end
        checks++; if (lat != 4) begin failures++; $display("FAIL b2b second_lat got=%0d exp=4", lat); end
        checks++; if (r !== 8'hF6) begin failures++; $display("FAIL b2b second_dout got=%h exp=f6", r); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int n;
        n = 0;
        start = 1'b1; din = 8'hC3; amt = 3'd5; mode = 2'b00;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL midrst busy_before got=%b exp=1", busy0); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL midrst busy got=%b exp=0", busy0); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL midrst done got=%b exp=0", done0); end
        checks++; if (dout0 !== 8'h00) begin failures++; $display("FAIL midrst dout got=%h exp=00", dout0); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0) n++;
        end
        checks++; if (n != 0) begin failures++; $display("FAIL midrst late_done got=%0d exp=0", n); end
    endtask

    task automatic test_bypass_b2b();
        start = 1'b1; din = 8'h3C; amt = 3'd0; mode = 2'b00;
        @(negedge clk);
        checks++; if (done1 !== 1'b1 || dout1 !== 8'h3C) begin failures++; $display("FAIL bypass_b2b first done=%b dout got=%h exp=3c", done1, dout1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL bypass_b2b busy got=%b exp=0", busy1); end
        din = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done1 !== 1'b1 || dout1 !== 8'hC3) begin failures++; $display("FAIL bypass_b2b second done=%b dout got=%h exp=c3", done1, dout1); end
        @(negedge clk);
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL bypass_b2b idle_done got=%b exp=0", done1); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            run_both(8'($urandom), 3'($urandom), 2'($urandom), "random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; din = 8'h00; amt = 3'd0; mode = 2'b00;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        test_bypass_b2b();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
